rca_pipe_addsub: RTL and testbench

RCA_PIPE_ADDSUB -- requirements
Module: rca_pipe_addsub

---
 rtl/rca_pipe_addsub.sv | 110 +++++++++++
 tb/tb_rca_pipe_addsub.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe_addsub.sv
// Pipelined add/subtract: one SEG-bit ripple segment per stage, operands skewed in, sum deskewed out.
// Define RCA_PIPE_SAT_EN to clamp signed overflow to the signed limit instead of wrapping.
module rca_pipe_addsub #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG = WIDTH / STAGES;
   localparam int unsigned LST = STAGES - 1;

   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic             r_sub [STAGES];
   logic             r_c   [STAGES];
   logic [WIDTH-1:0] r_s   [STAGES];
   logic             r_ovf;

   logic             w_adv;
   logic             w_vld_in [STAGES];
   logic [WIDTH-1:0] w_a_in   [STAGES];
   logic [WIDTH-1:0] w_b_in   [STAGES];
   logic             w_sub_in [STAGES];
   logic             w_c_in   [STAGES];
   logic [WIDTH-1:0] w_s_in   [STAGES];
   logic [SEG-1:0]   w_be     [STAGES];
   logic [SEG:0]     w_add    [STAGES];
   logic [WIDTH-1:0] w_s_nxt  [STAGES];
   logic             w_cmsb;
   logic             w_ovf;

   // Whole pipeline moves together; it only stalls when a finished result is refused.
   assign w_adv    = !r_vld[LST] || out_ready;
   assign in_ready = w_adv;

   always_comb begin
      w_vld_in[0] = in_valid;
      w_a_in[0]   = a;
      w_b_in[0]   = b;
      w_sub_in[0] = sub;
      w_c_in[0]   = sub | cin;
      w_s_in[0]   = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_vld_in[k] = r_vld[k-1];
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_sub_in[k] = r_sub[k-1];
         w_c_in[k]   = r_c[k-1];
         w_s_in[k]   = r_s[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_be[k]    = w_b_in[k][k*SEG +: SEG] ^ {SEG{w_sub_in[k]}};
         w_add[k]   = {1'b0, w_a_in[k][k*SEG +: SEG]} + {1'b0, w_be[k]} + {{SEG{1'b0}}, w_c_in[k]};
         w_s_nxt[k] = w_s_in[k];
         w_s_nxt[k][k*SEG +: SEG] = w_add[k][SEG-1:0];
      end
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
      w_cmsb = w_a_in[LST][WIDTH-1] ^ w_be[LST][SEG-1] ^ w_add[LST][SEG-1];
      w_ovf  = w_cmsb ^ w_add[LST][SEG];
`ifdef RCA_PIPE_SAT_EN
      if (w_ovf) begin
         w_s_nxt[LST] = w_a_in[LST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sub[k] <= 1'b0;
            r_c[k]   <= 1'b0;
            r_s[k]   <= '0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_vld_in[k];
            r_a[k]   <= w_a_in[k];
            r_b[k]   <= w_b_in[k];
            r_sub[k] <= w_sub_in[k];
            r_c[k]   <= w_add[k][SEG];
            r_s[k]   <= w_s_nxt[k];
         end
         r_ovf <= w_ovf;
      end
   end

   assign out_valid = r_vld[LST];
   assign sum       = r_s[LST];
   assign cout      = r_c[LST];
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Randomised and directed bench for rca_pipe_addsub against a plain-arithmetic reference model.
// Honours RCA_PIPE_SAT_EN in the same way as the design build.
module tb_rca_pipe_addsub;

   localparam int unsigned W  = 64;
   localparam int unsigned ST = 4;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, sum;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           t_in;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         cur_exp;
   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc      = 0;
   bit           lat_chk  = 1'b0;
   bit           bub_chk  = 1'b0;
   int           bub_start = 0;
   bit           prev_stall = 1'b0;
   logic [W+2:0] prev_vec;
   bit           hist [int];

   always #5 clk = ~clk;

   rca_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic check_eq(input string tag, input logic [W+2:0] got, input logic [W+2:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic s);
      logic [W:0]   full;
      logic [W-1:0] yy;
      exp_t         r;
      yy     = s ? ~y : y;
      full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : ci)};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (x[W-1] == yy[W-1]) && (r.sum[W-1] != x[W-1]);
`ifdef RCA_PIPE_SAT_EN
      if (r.ovf) r.sum = x[W-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      r.t_in = 0;
      return r;
   endfunction

   task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input bit ordy);
      in_valid  = v;
      a         = x;
      b         = y;
      cin       = ci;
      sub       = s;
      out_ready = ordy;
      cur_exp   = model(x, y, ci, s);
   endtask

   // One clock: sample mid-cycle, score the handshakes, then cross the rising edge.
   task automatic step(output bit acc);
      exp_t e;
      acc = 1'b0;
      #4;
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check_eq("hold_stable", {out_valid, cout, ovf, sum}, prev_vec);
         if (exp_q.size() == 0) begin
            check_eq("spurious_valid", {66'd0, out_valid}, '0);
         end else if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check_eq("sum", {3'd0, sum}, {3'd0, e.sum});
            check_eq("cout", {66'd0, cout}, {66'd0, e.cout});
            check_eq("ovf", {66'd0, ovf}, {66'd0, e.ovf});
            if (lat_chk) check_eq("latency", cyc - e.t_in, ST);
         end
         if (out_valid && !out_ready) check_eq("in_ready_bp", {66'd0, in_ready}, '0);
         if (bub_chk && cyc >= bub_start + int'(ST))
            check_eq("bubble_valid", {66'd0, out_valid}, {66'd0, hist[cyc-int'(ST)]});
         if (in_valid && in_ready) begin
            e      = cur_exp;
            e.t_in = cyc;
            exp_q.push_back(e);
            acc = 1'b1;
         end
         prev_stall = out_valid && !out_ready;
         prev_vec   = {out_valid, cout, ovf, sum};
      end
      hist[cyc] = acc;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
      bit acc;
      drive(1'b1, x, y, ci, s, 1'b1);
      cur_exp.sum  = es;
      cur_exp.cout = ec;
      cur_exp.ovf  = eo;
      step(acc);
      check_eq("dir_accept", {66'd0, acc}, {66'd0, 1'b1});
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(acc);
   endtask

   initial begin
      bit           acc;
      int           i;
      logic [W-1:0] opa [8];
      logic [W-1:0] opb [8];
      logic         opc [8];
      logic         ops [8];

      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(acc);
      rst_n = 1'b1;
      #1;
      check_eq("rst_out_valid", {66'd0, out_valid}, '0);
      check_eq("rst_sum", {3'd0, sum}, '0);
      check_eq("rst_cout", {66'd0, cout}, '0);
      check_eq("rst_ovf", {66'd0, ovf}, '0);
      check_eq("rst_in_ready", {66'd0, in_ready}, {66'd0, 1'b1});

      // Directed corner cases with exact latency.
      lat_chk = 1'b1;
      directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
      directed(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
`ifdef RCA_PIPE_SAT_EN
      directed(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
      directed(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
`else
      directed(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      directed(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
`endif
      directed(64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
      directed(64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);
      directed(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);

      // Alternating bubbles at full throughput.
      bub_start = cyc;
      bub_chk   = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive(k[0] == 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
         step(acc);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) step(acc);
      bub_chk = 1'b0;
      lat_chk = 1'b0;

      // Eight back-to-back ops with a three-cycle consumer stall.
      for (int k = 0; k < 8; k++) begin
         opa[k] = {$urandom, $urandom};
         opb[k] = {$urandom, $urandom};
         opc[k] = 1'($urandom);
         ops[k] = 1'($urandom);
      end
      i = 0;
      for (int j = 0; j < 40 && (i < 8 || exp_q.size() != 0); j++) begin
         if (i < 8) drive(1'b1, opa[i], opb[i], opc[i], ops[i], !(j >= 5 && j < 8));
         else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         step(acc);
         if (acc) i++;
      end
      check_eq("bp_all_issued", i, 8);
      check_eq("bp_drained", exp_q.size(), 0);

      // Reset while three ops are in flight.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
         step(acc);
      end
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      step(acc);
      rst_n = 1'b1;
      #1;
      check_eq("midrst_out_valid", {66'd0, out_valid}, '0);
      check_eq("midrst_sum", {3'd0, sum}, '0);
      for (int k = 0; k < 8; k++) step(acc);

      // Random traffic with random backpressure.
      for (int k = 0; k < 300; k++) begin
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
               ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
               1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
         step(acc);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(acc);
      check_eq("final_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
